// File: rtl/video_capture_pkg.sv
// Shared definitions for the video line capture tap.
//   cap_state_t    : capture FSM states
//   REG_*          : register word offsets inside the register half of the slot
//   CTRL_* / STAT_*: bit positions inside the CTRL and STATUS words
//   RAM_SEL_BIT    : slot address bit that selects the line RAM window
package video_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_WAIT_LINE,
        ST_CAPTURE,
        ST_DONE
    } cap_state_t;

    localparam logic [9:0] REG_CTRL   = 10'd0;
    localparam logic [9:0] REG_STATUS = 10'd1;

    localparam int CTRL_ARM_BIT   = 16;
    localparam int CTRL_ABORT_BIT = 17;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_ERR_BIT   = 2;
    localparam int STAT_COUNT_LSB = 16;

    localparam int RAM_SEL_BIT = 10;

    function automatic logic state_is_busy(input cap_state_t s);
        return (s == ST_WAIT_SOF) || (s == ST_WAIT_LINE) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/video_line_ram.sv
// Simple dual-port line buffer, 2**AW words of DW bits.
//   clk   : clock
//   we    : write enable (capture side)
//   waddr : write address
//   wdata : write data
//   re    : read enable (bus side); rdata only changes when re is high
//   raddr : read address
//   rdata : registered read data
module video_line_ram #(
    parameter int DW = 12,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/video_line_capture.sv
// Passive read-back tap on the video stream: on request, grabs one scan line
// of composited pixels into a line RAM that the CPU reads over the slot bus.
//   clk, reset       : system clock, synchronous active-high reset
//   cs/write/read    : slot strobes
//   addr, wr_data    : slot word address and write data
//   rd_data          : registered read data (valid the cycle after cs&read)
//   si_data          : {rgb, frame_start} stream tap
//   si_valid         : stream pixel transfer qualifier
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | not armed
// ST_WAIT_SOF  | armed, waiting for a frame_start pixel
// ST_WAIT_LINE | frame synced, waiting for px 0 of the target line
// ST_CAPTURE   | writing pixels of the target line into the RAM
// ST_DONE      | full line captured, RAM content valid
module video_line_capture
    import video_capture_pkg::*;
#(
    parameter int CD   = 12,
    parameter int HMAX = 640,
    parameter int VMAX = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        write,
    input  logic        read,
    input  logic [13:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic [CD:0] si_data,
    input  logic        si_valid
);

    localparam logic [9:0]  PX_LAST = 10'(HMAX - 1);
    localparam logic [9:0]  LN_LAST = 10'(VMAX - 1);
    localparam logic [10:0] HMAX_L  = 11'(HMAX);
    localparam logic [10:0] VMAX_L  = 11'(VMAX);

    cap_state_t    state, state_n;
    logic [9:0]    target, target_n;
    logic          done, done_n;
    logic          err, err_n;
    logic [9:0]    count, count_n;

    logic          frame_start;
    logic [CD-1:0] rgb;
    logic [9:0]    px, ln;
    logic [9:0]    cur_px, cur_ln;
    logic          last_px;

    logic          ctrl_wr, arm, abort, target_ok;
    logic [9:0]    new_target;
    logic          start_cap;
    logic          ram_we;

    logic          ram_rd_in_range, ram_re;
    logic [CD-1:0] ram_q;
    logic          rd_ram;
    logic [31:0]   rd_reg;
    logic [31:0]   status_word;

    logic          unused_bits;
    assign unused_bits = ^{addr[13:11], wr_data[31:18], wr_data[15:10]};

    assign frame_start = si_data[0];
    assign rgb         = si_data[CD:1];

    // px/ln hold the position of the next pixel; a frame_start pixel is
    // forced to (0,0) so the counters resync on every frame.
    always_comb begin
        cur_px = frame_start ? '0 : px;
        cur_ln = frame_start ? '0 : ln;
    end
    assign last_px = (cur_px == PX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            px <= '0;
            ln <= '0;
        end else if (si_valid) begin
            if (last_px) begin
                px <= '0;
                ln <= (cur_ln == LN_LAST) ? '0 : cur_ln + 10'd1;
            end else begin
                px <= cur_px + 10'd1;
                ln <= cur_ln;
            end
        end
    end

    assign ctrl_wr    = cs & write & ~addr[RAM_SEL_BIT] & (addr[9:0] == REG_CTRL);
    assign arm        = ctrl_wr & wr_data[CTRL_ARM_BIT];
    assign abort      = ctrl_wr & wr_data[CTRL_ABORT_BIT];
    assign new_target = wr_data[9:0];
    assign target_ok  = {1'b0, new_target} < VMAX_L;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            target <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            count  <= '0;
        end else begin
            state  <= state_n;
            target <= target_n;
            done   <= done_n;
            err    <= err_n;
            count  <= count_n;
        end
    end

    // A CTRL write shadows any stream event in the same cycle, so nothing
    // is written to the RAM while the FSM is being re-armed or aborted.
    always_comb begin
        state_n   = state;
        target_n  = target;
        done_n    = done;
        err_n     = err;
        count_n   = count;
        ram_we    = 1'b0;
        start_cap = 1'b0;
        if (abort) begin
            state_n = ST_IDLE;
            done_n  = 1'b0;
        end else if (arm) begin
            done_n  = 1'b0;
            count_n = '0;
            if (target_ok) begin
                state_n  = ST_WAIT_SOF;
                err_n    = 1'b0;
                target_n = new_target;
            end else begin
                state_n = ST_IDLE;
                err_n   = 1'b1;
            end
        end else if (si_valid) begin
            case (state)
                ST_WAIT_SOF: begin
                    if (frame_start) begin
                        if (target == '0) begin
                            start_cap = 1'b1;
                        end else begin
                            state_n = ST_WAIT_LINE;
                        end
                    end
                end
                ST_WAIT_LINE: begin
                    if ((cur_ln == target) && (cur_px == '0)) begin
                        start_cap = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (frame_start) begin
                        err_n   = 1'b1;
                        state_n = ST_WAIT_SOF;
                    end else begin
                        ram_we  = 1'b1;
                        count_n = count + 10'd1;
                        if (last_px) begin
                            state_n = ST_DONE;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (start_cap) begin
                ram_we  = 1'b1;
                count_n = 10'd1;
                state_n = last_px ? ST_DONE : ST_CAPTURE;
                done_n  = last_px;
            end
        end
    end

    video_line_ram #(
        .DW (CD),
        .AW (10)
    ) u_line_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (cur_px),
        .wdata (rgb),
        .re    (ram_re),
        .raddr (addr[9:0]),
        .rdata (ram_q)
    );

    always_comb begin
        status_word                               = '0;
        status_word[STAT_BUSY_BIT]                = state_is_busy(state);
        status_word[STAT_DONE_BIT]                = done;
        status_word[STAT_ERR_BIT]                 = err;
        status_word[STAT_COUNT_LSB +: 10]         = count;
    end

    assign ram_rd_in_range = {1'b0, addr[9:0]} < HMAX_L;
    assign ram_re          = cs & read & addr[RAM_SEL_BIT] & ram_rd_in_range;

    // rd_data is a mux of two registers: the RAM output register and a
    // register-read holding register. Out-of-range RAM reads select the
    // holding register loaded with zero, so every read path has one cycle
    // of latency and the value holds until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ram <= 1'b0;
            rd_reg <= '0;
        end else if (cs & read) begin
            if (addr[RAM_SEL_BIT]) begin
                rd_ram <= ram_rd_in_range;
                rd_reg <= '0;
            end else begin
                rd_ram <= 1'b0;
                rd_reg <= (addr[9:0] == REG_STATUS) ? status_word : '0;
            end
        end
    end

    assign rd_data = rd_ram ? 32'(ram_q) : rd_reg;

endmodule

// File: tb/tb_video_line_capture.sv
module tb_video_line_capture;

    localparam int CD = 12;
    localparam int H  = 20;
    localparam int V  = 6;

    localparam logic [31:0] ARM   = 32'h0001_0000;
    localparam logic [31:0] ABORT = 32'h0002_0000;
    localparam logic [13:0] A_STATUS = 14'd1;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, write, read;
    logic [13:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [CD:0] si_data;
    logic        si_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] d;

    always #5 clk = ~clk;

    video_line_capture #(.CD(CD), .HMAX(H), .VMAX(V)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .write    (write),
        .read     (read),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .si_data  (si_data),
        .si_valid (si_valid)
    );

    function automatic logic [CD-1:0] pix(input int f, input int l, input int p);
        return CD'(f * 256 + l * 32 + p);
    endfunction

    function automatic logic [31:0] st(input bit b, input bit dn, input bit e, input int c);
        return {6'b0, 10'(c), 13'b0, e, dn, b};
    endfunction

    function automatic logic [13:0] ram_a(input int i);
        return 14'(1024 + i);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_px(input int f, input int l, input int p);
        si_valid = 1'b1;
        si_data  = {pix(f, l, p), (l == 0 && p == 0)};
        tick();
        si_valid = 1'b0;
        si_data  = {CD'($urandom), 1'b1};
    endtask

    task automatic send_range(input int f, input int l0, input int p0, input int n, input bit gaps);
        int l = l0;
        int p = p0;
        repeat (n) begin
            send_px(f, l, p);
            if (gaps && (p % 3 == 1)) tick();
            p++;
            if (p == H) begin
                p = 0;
                l++;
                if (l == V) l = 0;
            end
        end
    endtask

    task automatic bus_write(input logic [31:0] v);
        cs = 1'b1; write = 1'b1; addr = 14'd0; wr_data = v;
        tick();
        cs = 1'b0; write = 1'b0; wr_data = '0;
    endtask

    task automatic bus_read(input logic [13:0] a, output logic [31:0] v);
        cs = 1'b1; read = 1'b1; addr = a;
        tick();
        cs = 1'b0; read = 1'b0;
        v = rd_data;
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; write = 1'b0; read = 1'b0;
        addr = '0; wr_data = '0; si_data = '0; si_valid = 1'b0;
        tick(); tick();
        check("reset_rd_data", rd_data, 32'h0);
        reset = 1'b0;
        bus_read(A_STATUS, d);
        check("reset_status", d, 32'h0);

        // line 0 capture; busy must drop on the edge writing the last pixel
        bus_write(ARM | 32'd0);
        bus_read(A_STATUS, d);
        check("arm0_busy", d, st(1, 0, 0, 0));
        send_range(0, 3, 0, 5, 0);
        send_range(0, 0, 0, H - 1, 0);
        si_valid = 1'b1; si_data = {pix(0, 0, H - 1), 1'b0};
        cs = 1'b1; read = 1'b1; addr = A_STATUS;
        tick();
        si_valid = 1'b0; cs = 1'b0; read = 1'b0;
        check("last_px_status_before", rd_data, st(1, 0, 0, H - 1));
        bus_read(A_STATUS, d);
        check("line0_done", d, st(0, 1, 0, H));
        send_range(0, 1, 0, H * (V - 1), 0);
        send_range(1, 0, 0, H * V, 0);
        bus_read(A_STATUS, d);
        check("done_holds", d, st(0, 1, 0, H));
        bus_read(ram_a(5), d);
        check("line0_ram5", d, 32'(pix(0, 0, 5)));
        bus_read(ram_a(H - 1), d);
        check("line0_ramlast", d, 32'(pix(0, 0, H - 1)));

        // last line with gaps in si_valid
        bus_write(ARM | 32'(V - 1));
        send_range(2, 0, 0, H * V, 1);
        bus_read(A_STATUS, d);
        check("lastline_done", d, st(0, 1, 0, H));
        bus_read(ram_a(0), d);
        check("lastline_ram0", d, 32'(pix(2, V - 1, 0)));
        bus_read(ram_a(7), d);
        check("lastline_ram7", d, 32'(pix(2, V - 1, 7)));
        bus_read(ram_a(H - 1), d);
        check("lastline_ramlast", d, 32'(pix(2, V - 1, H - 1)));
        bus_read(ram_a(H), d);
        check("ram_oob_hmax", d, 32'h0);
        bus_read(ram_a(1023), d);
        check("ram_oob_1023", d, 32'h0);

        // frame_start mid-capture: err, retry on the following frame
        bus_write(ARM | 32'd2);
        send_range(4, 0, 0, 2 * H + 10, 0);
        send_px(5, 0, 0);
        bus_read(A_STATUS, d);
        check("midcap_err_bits", {29'b0, d[2:0]}, 32'h5);
        send_range(5, 0, 1, H * V - 1, 0);
        send_range(6, 0, 0, H * V, 0);
        bus_read(A_STATUS, d);
        check("retry_done_err", d, st(0, 1, 1, H));
        bus_read(ram_a(3), d);
        check("retry_ram3", d, 32'(pix(6, 2, 3)));
        bus_read(ram_a(12), d);
        check("retry_ram12", d, 32'(pix(6, 2, 12)));

        // arm clears err; abort; out-of-range target
        bus_write(ARM | 32'd1);
        bus_read(A_STATUS, d);
        check("rearm_clears", d, st(1, 0, 0, 0));
        bus_write(ABORT);
        bus_read(A_STATUS, d);
        check("abort_idle", {30'b0, d[1:0]}, 32'h0);
        bus_write(ARM | 32'(V));
        bus_read(A_STATUS, d);
        check("bad_target_bits", {29'b0, d[2:0]}, 32'h4);
        send_range(3, 0, 0, H * V, 0);
        bus_read(A_STATUS, d);
        check("bad_target_stays_idle", {29'b0, d[2:0]}, 32'h4);

        // arm and abort in one write
        bus_write(ARM | 32'd1);
        bus_write(ARM | ABORT | 32'd1);
        bus_read(A_STATUS, d);
        check("arm_abort_idle", {30'b0, d[1:0]}, 32'h0);
        send_range(3, 0, 0, H * V, 0);
        bus_read(A_STATUS, d);
        check("arm_abort_no_capture", {30'b0, d[1:0]}, 32'h0);

        // reset during capture, partial-line read, then recapture
        bus_write(ARM | 32'd1);
        send_range(7, 0, 0, H + 8, 0);
        bus_read(ram_a(3), d);
        check("partial_ram3", d, 32'(pix(7, 1, 3)));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_rd_data", rd_data, 32'h0);
        bus_read(A_STATUS, d);
        check("midreset_status", d, 32'h0);
        bus_write(ARM | 32'd1);
        send_range(8, 0, 0, H * V, 0);
        bus_read(A_STATUS, d);
        check("post_reset_done", d, st(0, 1, 0, H));
        bus_read(ram_a(H - 1), d);
        check("post_reset_ramlast", d, 32'(pix(8, 1, H - 1)));

        // re-arm while busy in the same cycle as a frame_start pixel
        bus_write(ARM | 32'd0);
        si_valid = 1'b1; si_data = {pix(9, 0, 0), 1'b1};
        cs = 1'b1; write = 1'b1; addr = 14'd0; wr_data = ARM | 32'd0;
        tick();
        si_valid = 1'b0; cs = 1'b0; write = 1'b0; wr_data = '0;
        send_range(9, 0, 1, 3, 0);
        bus_read(A_STATUS, d);
        check("ctrl_beats_stream", d, st(1, 0, 0, 0));
        send_range(9, 0, 4, H * V - 4, 0);
        send_range(10, 0, 0, H, 0);
        bus_read(A_STATUS, d);
        check("after_rearm_done", d, st(0, 1, 0, H));
        bus_read(ram_a(9), d);
        check("after_rearm_ram9", d, 32'(pix(10, 0, 9)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
